clic_arbiter: RTL and testbench

Interrupt arbiter and preemption scheduler for the n_clic interrupt controller. It takes per-source pending, enable and priority state, selects the highest-priority eligible source, and runs a request/acknowledge handshake with the core. It tracks nested preemption levels on a priority stack and pops that stack on interrupt return. It sits between the n_clic CSR block (configuration and pending state) and the core's trap-entry logic.

---
 rtl/clic_arbiter.sv | 132 +++++++++++++
 tb/tb_clic_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_arbiter.sv
// Interrupt arbiter and nested-preemption scheduler for the n_clic controller.
// Optional macro CLIC_TAIL_CHAIN_EN: arbitration in IDLE sees the post-return level.
module clic_arbiter #(
   parameter int N_SRC       = 8,
   parameter int PRIO_BITS   = 3,
   parameter int STACK_DEPTH = 4,
   localparam int ID_W = $clog2(N_SRC),
   localparam int D_W  = $clog2(STACK_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_SRC-1:0]           pend,
   input  logic [N_SRC-1:0]           en,
   input  logic [N_SRC*PRIO_BITS-1:0] prio,
   input  logic                       irq_ack,
   input  logic                       irq_ret,
   output logic                       irq_req,
   output logic [ID_W-1:0]            irq_id,
   output logic [PRIO_BITS-1:0]       irq_prio,
   output logic [PRIO_BITS-1:0]       level,
   output logic [D_W-1:0]             depth,
   output logic [N_SRC-1:0]           pend_clr
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;
   localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [D_W-1:0] DEPTH_MAX = D_W'(STACK_DEPTH);

   logic [0:0]           state_reg;
   logic [ID_W-1:0]      irq_id_reg;
   logic [PRIO_BITS-1:0] irq_prio_reg;
   logic [PRIO_BITS-1:0] level_reg;
   logic [D_W-1:0]       depth_reg;
   logic [N_SRC-1:0]     pend_clr_reg;
   logic [PRIO_BITS-1:0] stack_mem [STACK_DEPTH];

   logic [PRIO_BITS-1:0] src_prio [N_SRC];
   logic [N_SRC-1:0]     elig;
   logic [PRIO_BITS-1:0] eval_level;
   logic [D_W-1:0]       eval_depth;
   logic [PRIO_BITS-1:0] stack_top;
   logic [SP_W-1:0]      push_idx;
   logic [SP_W-1:0]      top_idx;
   logic                 ack_fire;
   logic                 pop_ok;
   logic                 any_elig;
   logic [ID_W-1:0]      best_id;
   logic [PRIO_BITS-1:0] best_prio;

   assign ack_fire  = (state_reg == ST_REQ) && irq_ack;
   assign pop_ok    = irq_ret && (depth_reg != '0);
   assign push_idx  = SP_W'(depth_reg);
   assign top_idx   = SP_W'(depth_reg - D_W'(1));
   assign stack_top = stack_mem[top_idx];

`ifdef CLIC_TAIL_CHAIN_EN
   // Look through a same-cycle return so a waiting source chains straight in.
   assign eval_level = pop_ok ? stack_top : level_reg;
   assign eval_depth = pop_ok ? depth_reg - D_W'(1) : depth_reg;
`else
   assign eval_level = level_reg;
   assign eval_depth = depth_reg;
`endif

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
         assign src_prio[gi] = prio[gi*PRIO_BITS +: PRIO_BITS];
         assign elig[gi]     = pend[gi] & en[gi] & (src_prio[gi] > eval_level)
                               & (eval_depth < DEPTH_MAX);
      end
   endgenerate

   // Strict greater-than keeps the lowest index on ties; eligible implies prio > 0.
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (elig[i] && (src_prio[i] > best_prio)) begin
            best_id   = ID_W'(i);
            best_prio = src_prio[i];
         end
      end
   end

   assign any_elig = |elig;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         irq_id_reg   <= '0;
         irq_prio_reg <= '0;
         level_reg    <= '0;
         depth_reg    <= '0;
         pend_clr_reg <= '0;
      end else begin
         pend_clr_reg <= '0;
         if (ack_fire) begin
            // A simultaneous valid return cancels the push: depth stays put.
            pend_clr_reg <= N_SRC'(1) << irq_id_reg;
            level_reg    <= irq_prio_reg;
            if (!pop_ok) begin
               depth_reg <= depth_reg + D_W'(1);
            end
            state_reg <= ST_IDLE;
         end else if (pop_ok) begin
            level_reg <= stack_top;
            depth_reg <= depth_reg - D_W'(1);
         end
         if ((state_reg == ST_IDLE) && any_elig) begin
            state_reg    <= ST_REQ;
            irq_id_reg   <= best_id;
            irq_prio_reg <= best_prio;
         end
      end
   end

   // Stack contents are left intact on pop; only a lone push writes.
   always_ff @(posedge clk) begin
      if (ack_fire && !pop_ok) begin
         stack_mem[push_idx] <= level_reg;
      end
   end

   assign irq_req  = (state_reg == ST_REQ);
   assign irq_id   = irq_id_reg;
   assign irq_prio = irq_prio_reg;
   assign level    = level_reg;
   assign depth    = depth_reg;
   assign pend_clr = pend_clr_reg;

endmodule

// File: tb/tb_clic_arbiter.sv
// Directed self-checking bench for clic_arbiter (default 8 sources, 3-bit prio, depth 4).
module tb_clic_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pend;
   logic [7:0]  en;
   logic [23:0] prio;
   logic        irq_ack;
   logic        irq_ret;
   logic        irq_req;
   logic [2:0]  irq_id;
   logic [2:0]  irq_prio;
   logic [2:0]  level;
   logic [2:0]  depth;
   logic [7:0]  pend_clr;

   int total  = 0;
   int passed = 0;

   clic_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .pend     (pend),
      .en       (en),
      .prio     (prio),
      .irq_ack  (irq_ack),
      .irq_ret  (irq_ret),
      .irq_req  (irq_req),
      .irq_id   (irq_id),
      .irq_prio (irq_prio),
      .level    (level),
      .depth    (depth),
      .pend_clr (pend_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_prio(input int src, input logic [2:0] p);
      prio[src*3 +: 3] = p;
   endtask

   task automatic do_reset();
      reset = 1'b0; pend = '0; en = '0; prio = '0; irq_ack = 1'b0; irq_ret = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0; pend = '0; en = '0; prio = '0; irq_ack = 1'b0; irq_ret = 1'b0;
      #3;
      chk("rst_req",   32'(irq_req),  32'h0);
      chk("rst_id",    32'(irq_id),   32'h0);
      chk("rst_prio",  32'(irq_prio), 32'h0);
      chk("rst_level", 32'(level),    32'h0);
      chk("rst_depth", 32'(depth),    32'h0);
      chk("rst_clr",   32'(pend_clr), 32'h0);
      do_reset();

      // single source
      pend = 8'h08; en = 8'h08; set_prio(3, 3'd2);
      chk("s1_pre_req", 32'(irq_req), 32'h0);
      step();
      chk("s1_req",  32'(irq_req),  32'h1);
      chk("s1_id",   32'(irq_id),   32'h3);
      chk("s1_prio", 32'(irq_prio), 32'h2);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0; pend = '0;
      chk("s1_level", 32'(level),    32'h2);
      chk("s1_depth", 32'(depth),    32'h1);
      chk("s1_clr",   32'(pend_clr), 32'h08);
      chk("s1_req_lo", 32'(irq_req), 32'h0);
      step();
      chk("s1_clr_end", 32'(pend_clr), 32'h00);

      // priority and tie
      pend = 8'h26; en = 8'h26; set_prio(1, 3'd4); set_prio(2, 3'd6); set_prio(5, 3'd6);
      step();
      chk("tie_id",   32'(irq_id),   32'h2);
      chk("tie_prio", 32'(irq_prio), 32'h6);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0; pend = '0;
      chk("tie_level", 32'(level),    32'h6);
      chk("tie_clr",   32'(pend_clr), 32'h04);
      irq_ret = 1'b1;
      step();
      irq_ret = 1'b0;
      chk("tie_ret_lvl", 32'(level), 32'h2);
      chk("tie_ret_dep", 32'(depth), 32'h1);

      // preemption and stack unwinding
      pend = 8'h40; en = 8'h40; set_prio(6, 3'd5);
      step();
      chk("pre_id", 32'(irq_id), 32'h6);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0; pend = '0;
      chk("pre_level", 32'(level), 32'h5);
      chk("pre_depth", 32'(depth), 32'h2);
      irq_ret = 1'b1;
      step();
      chk("ret1_level", 32'(level), 32'h2);
      chk("ret1_depth", 32'(depth), 32'h1);
      step();
      chk("ret2_level", 32'(level), 32'h0);
      chk("ret2_depth", 32'(depth), 32'h0);
      step();
      irq_ret = 1'b0;
      chk("ret3_level", 32'(level), 32'h0);
      chk("ret3_depth", 32'(depth), 32'h0);

      // fill the stack to its limit
      do_reset();
      en = 8'hFF;
      for (int k = 1; k <= 4; k++) begin
         pend = 8'(1 << k); set_prio(k, 3'(k));
         step();
         irq_ack = 1'b1; pend = '0;
         step();
         irq_ack = 1'b0;
         step();
      end
      chk("full_depth", 32'(depth), 32'h4);
      chk("full_level", 32'(level), 32'h4);
      pend = 8'h80; set_prio(7, 3'd7);
      step(); step(); step();
      chk("full_blocked", 32'(irq_req), 32'h0);
      irq_ret = 1'b1;
      step();
      irq_ret = 1'b0;
      chk("full_ret_dep", 32'(depth), 32'h3);
      chk("full_ret_lvl", 32'(level), 32'h3);
`ifdef CLIC_TAIL_CHAIN_EN
      chk("full_ret_req", 32'(irq_req), 32'h1);
`else
      chk("full_ret_req", 32'(irq_req), 32'h0);
`endif
      step();
      chk("full_req", 32'(irq_req), 32'h1);
      chk("full_id",  32'(irq_id),  32'h7);

      // simultaneous ack and return
      do_reset();
      pend = 8'h01; en = 8'h11; set_prio(0, 3'd3); set_prio(4, 3'd6);
      step();
      irq_ack = 1'b1; pend = '0;
      step();
      irq_ack = 1'b0;
      chk("sim_pre_lvl", 32'(level), 32'h3);
      pend = 8'h10;
      step();
      chk("sim_req_prio", 32'(irq_prio), 32'h6);
      irq_ack = 1'b1; irq_ret = 1'b1; pend = '0;
      step();
      irq_ack = 1'b0; irq_ret = 1'b0;
      chk("sim_level", 32'(level),    32'h6);
      chk("sim_depth", 32'(depth),    32'h1);
      chk("sim_clr",   32'(pend_clr), 32'h10);
      irq_ret = 1'b1;
      step();
      irq_ret = 1'b0;
      chk("sim_pop_lvl", 32'(level), 32'h0);
      chk("sim_pop_dep", 32'(depth), 32'h0);

      // tail chain on return
      do_reset();
      pend = 8'h04; en = 8'h05; set_prio(2, 3'd5); set_prio(0, 3'd3);
      step();
      irq_ack = 1'b1; pend = '0;
      step();
      irq_ack = 1'b0;
      pend = 8'h01;
      step(); step();
      chk("tc_level",   32'(level),   32'h5);
      chk("tc_wait",    32'(irq_req), 32'h0);
      irq_ret = 1'b1;
      step();
      irq_ret = 1'b0;
`ifdef CLIC_TAIL_CHAIN_EN
      chk("tc_t1_req", 32'(irq_req), 32'h1);
`else
      chk("tc_t1_req", 32'(irq_req), 32'h0);
`endif
      step();
      chk("tc_t2_req",  32'(irq_req),  32'h1);
      chk("tc_t2_id",   32'(irq_id),   32'h0);
      chk("tc_t2_prio", 32'(irq_prio), 32'h3);

      // asynchronous reset while a request is outstanding
      irq_ack = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("ar_req",   32'(irq_req),  32'h0);
      chk("ar_id",    32'(irq_id),   32'h0);
      chk("ar_prio",  32'(irq_prio), 32'h0);
      chk("ar_level", 32'(level),    32'h0);
      chk("ar_depth", 32'(depth),    32'h0);
      step();
      chk("ar_clr",   32'(pend_clr), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
